// File: rtl/ptos_pkg.sv
// Shared types and constants for the multi-lane parallel-to-serial IDLE transmitter.
package ptos_pkg;

  typedef enum logic [1:0] {
    OFF,
    WARMUP,
    RUN
  } ptos_state_e;

  typedef enum logic [1:0] {
    LOAD_ZERO,
    LOAD_IDLE,
    LOAD_DATA
  } load_sel_e;

  localparam logic [7:0] K28_5 = 8'hBC;

  // Counter width that stays legal when the range collapses to a single value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ptos_lane_shifter.sv
// One serial lane: parallel load of a symbol, then one bit per clock from the selected edge.
module ptos_lane_shifter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             serial
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= value;
    end else if (MSB_FIRST) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
    end else begin
      sr <= {1'b0, sr[WIDTH-1:1]};
    end
  end

  assign serial = MSB_FIRST ? sr[WIDTH-1] : sr[0];

endmodule

// File: rtl/ptos_idle_multilane.sv
// Multi-lane serialiser: MIN_IDLE warm-up IDLEs after activation, then data or IDLE filler
// on a shared WIDTH-clock symbol boundary; one-cycle in_ready pulse at each accepting boundary.
module ptos_idle_multilane
  import ptos_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               LANES     = 2,
  parameter logic [WIDTH-1:0] IDLE_SYM  = WIDTH'(K28_5),
  parameter int               MIN_IDLE  = 4,
  parameter bit               MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   active,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LANES-1:0]       out_serial,
  output logic                   sym_start,
  output logic                   is_idle,
  output logic                   link_up
);

  localparam int CNT_W  = cnt_width(WIDTH);
  localparam int IDLE_W = cnt_width(MIN_IDLE + 1);

  ptos_state_e       state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [IDLE_W-1:0] idle_cnt, idle_nxt;
  logic              is_idle_nxt;
  logic              boundary;
  logic              load;
  load_sel_e         load_sel;

  assign boundary = (cnt == CNT_W'(WIDTH - 1));

  // Reset gates the handshake so no symbol is accepted on an edge that discards it.
  assign in_ready = !reset && active && boundary &&
                    ((state == RUN) ||
                     ((state == WARMUP) && (idle_cnt == IDLE_W'(MIN_IDLE))));

  assign link_up = (state == RUN);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idle_nxt    = idle_cnt;
    is_idle_nxt = is_idle;
    load        = 1'b0;
    load_sel    = LOAD_ZERO;
    unique case (state)
      OFF: begin
        cnt_nxt = '0;
        if (active) begin
          state_nxt   = WARMUP;
          load        = 1'b1;
          load_sel    = LOAD_IDLE;
          idle_nxt    = IDLE_W'(1);
          is_idle_nxt = 1'b1;
        end
      end
      WARMUP, RUN: begin
        cnt_nxt = boundary ? '0 : cnt + CNT_W'(1);
        if (boundary) begin
          load = 1'b1;
          if (!active) begin
            state_nxt   = OFF;
            load_sel    = LOAD_ZERO;
            idle_nxt    = '0;
            is_idle_nxt = 1'b0;
          end else if ((state == WARMUP) && (idle_cnt < IDLE_W'(MIN_IDLE))) begin
            load_sel    = LOAD_IDLE;
            idle_nxt    = idle_cnt + IDLE_W'(1);
            is_idle_nxt = 1'b1;
          end else begin
            state_nxt = RUN;
            if (in_valid) begin
              load_sel    = LOAD_DATA;
              is_idle_nxt = 1'b0;
            end else begin
              load_sel    = LOAD_IDLE;
              is_idle_nxt = 1'b1;
            end
          end
        end
      end
      default: begin
        state_nxt = OFF;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= OFF;
      cnt       <= '0;
      idle_cnt  <= '0;
      is_idle   <= 1'b0;
      sym_start <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idle_cnt  <= idle_nxt;
      is_idle   <= is_idle_nxt;
      sym_start <= (state_nxt != OFF) && (cnt_nxt == '0);
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] value;

    always_comb begin
      value = '0;
      unique case (load_sel)
        LOAD_IDLE: value = IDLE_SYM;
        LOAD_DATA: value = in_data[i*WIDTH +: WIDTH];
        default:   value = '0;
      endcase
    end

    ptos_lane_shifter #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
    ) u_shifter (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .value  (value),
      .serial (out_serial[i])
    );
  end

endmodule

// File: tb/tb_ptos_idle_multilane.sv
// Directed and randomised checks of ptos_idle_multilane against a symbol-level reference model.
module tb_ptos_idle_multilane;

  localparam int         W        = 8;
  localparam int         L        = 2;
  localparam int         MIN_IDLE = 4;
  localparam logic [7:0] IDLE     = 8'hBC;

  logic          clk = 1'b0;
  logic          reset, active, in_valid;
  logic [L*W-1:0] in_data;
  logic          in_ready, sym_start, is_idle, link_up;
  logic [L-1:0]  out_serial;

  always #5 clk = ~clk;

  ptos_idle_multilane #(
    .WIDTH     (W),
    .LANES     (L),
    .IDLE_SYM  (8'hBC),
    .MIN_IDLE  (MIN_IDLE),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .active     (active),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_serial (out_serial),
    .sym_start  (sym_start),
    .is_idle    (is_idle),
    .link_up    (link_up)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: link on/off, symbols started since activation, bit position in symbol.
  bit          m_on;
  int          m_no, m_pos;
  logic [7:0]  m_sym [L];
  bit          m_idle;
  logic [15:0] acc_q [$];

  // Receiver-side deserialiser built only from observed outputs.
  bit          rx_active, rx_idle;
  int          rx_bits;
  logic [7:0]  rx_sh [L];
  logic [15:0] rx_log [$];

  logic [L-1:0] last_serial;
  logic         last_ready, last_link;
  int           ready_pulses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [L-1:0] exp_ser;
    logic [15:0]  word;
    for (int l = 0; l < L; l++) exp_ser[l] = m_on ? m_sym[l][W-1-m_pos] : 1'b0;
    chk("out_serial", out_serial, exp_ser);
    chk("in_ready", in_ready, !reset && m_on && active && (m_pos == W-1) && (m_no >= MIN_IDLE));
    chk("sym_start", sym_start, m_on && (m_pos == 0));
    chk("is_idle", is_idle, m_on && m_idle);
    chk("link_up", link_up, m_on && (m_no > MIN_IDLE));
    last_serial = out_serial;
    last_ready  = in_ready;
    last_link   = link_up;
    if (in_ready) ready_pulses++;
    if (sym_start) begin
      rx_active = 1'b1;
      rx_bits   = 0;
      rx_idle   = is_idle;
    end
    if (rx_active) begin
      for (int l = 0; l < L; l++) rx_sh[l] = {rx_sh[l][6:0], out_serial[l]};
      rx_bits++;
      if (rx_bits == W) begin
        rx_active = 1'b0;
        word = {rx_sh[1], rx_sh[0]};
        if (rx_idle) chk("rx_idle_sym", word, {IDLE, IDLE});
        else begin
          rx_log.push_back(word);
          if (acc_q.size() > 0) chk("rx_data", word, acc_q.pop_front());
          else chk("rx_spurious", acc_q.size(), 1);
        end
      end
    end
  endtask

  task automatic model_step(input logic r, input logic a, input logic v, input logic [15:0] d);
    if (r) begin
      m_on = 0; m_pos = 0; m_no = 0; m_idle = 0;
      acc_q.delete();
      rx_active = 1'b0;
    end else if (!m_on) begin
      if (a) begin
        m_on = 1; m_no = 1; m_pos = 0; m_idle = 1;
        for (int l = 0; l < L; l++) m_sym[l] = IDLE;
      end
    end else if (m_pos < W-1) begin
      m_pos++;
    end else if (!a) begin
      m_on = 0; m_pos = 0; m_idle = 0;
    end else begin
      m_pos = 0;
      if (m_no <= MIN_IDLE) m_no++;
      if (m_no > MIN_IDLE && v) begin
        m_sym[0] = d[7:0]; m_sym[1] = d[15:8]; m_idle = 0;
        acc_q.push_back(d);
      end else begin
        for (int l = 0; l < L; l++) m_sym[l] = IDLE;
        m_idle = 1;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic a, input logic v, input logic [15:0] d);
    reset = r; active = a; in_valid = v; in_data = d;
    #1;
    check_outputs();
    model_step(r, a, v, d);
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] d);
    bit got = 0;
    for (int n = 0; n < 64 && !got; n++) begin
      cycle(1'b0, 1'b1, 1'b1, d);
      got = last_ready;
    end
    chk("send_handshake", got, 1'b1);
  endtask

  task automatic warmup_check(input string tag);
    int         first_k = -1;
    logic [7:0] cap = '0;
    for (int k = 0; k < 40; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0);
      if (k >= 1 && k <= 8) cap = {cap[6:0], last_serial[0]};
      if (last_ready && first_k < 0) first_k = k;
    end
    chk({tag, "_first_ready"}, first_k, 32);
    chk({tag, "_lane0_idle"}, cap, 8'hBC);
  endtask

  initial begin
    bit act;
    reset = 1'b1; active = 1'b1; in_valid = 1'b0; in_data = '0;
    m_on = 0; m_no = 0; m_pos = 0; m_idle = 0;
    rx_active = 0; rx_bits = 0; rx_idle = 0; ready_pulses = 0;
    @(negedge clk);

    // Reset held with active high: everything stays quiet.
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 16'h0);

    // Warm-up from reset, then IDLE filler in RUN.
    warmup_check("warmup1");

    // Held in_valid: one acceptance per symbol.
    ready_pulses = 0;
    repeat (64) cycle(1'b0, 1'b1, 1'b1, 16'hA55A);
    chk("ready_pulses", ready_pulses, 8);
    repeat (8) cycle(1'b0, 1'b1, 1'b0, 16'h0);

    // Data, one skipped boundary, data: no loss, no duplication.
    rx_log.delete();
    send(16'h1111);
    repeat (8) cycle(1'b0, 1'b1, 1'b0, 16'h0);
    send(16'h2222);
    repeat (12) cycle(1'b0, 1'b1, 1'b0, 16'h0);
    chk("seq_count", rx_log.size(), 2);
    if (rx_log.size() == 2) begin
      chk("seq_first", rx_log[0], 16'h1111);
      chk("seq_second", rx_log[1], 16'h2222);
    end

    // active drops at bit 3 of a data symbol: symbol completes, link goes down.
    rx_log.delete();
    send(16'h3C3C);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 16'h0);
    repeat (20) cycle(1'b0, 1'b0, 1'b0, 16'h0);
    chk("drop_rx_count", rx_log.size(), 1);
    if (rx_log.size() == 1) chk("drop_rx_data", rx_log[0], 16'h3C3C);
    chk("drop_link", last_link, 1'b0);
    chk("drop_serial", last_serial, 2'b00);
    warmup_check("warmup2");

    // Reset mid-symbol in RUN discards the partial symbol.
    send(16'h5A5A);
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    chk("rst_mid_serial", last_serial, 2'b00);
    chk("rst_mid_link", last_link, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 16'h0);

    // Randomised traffic with occasional link drops and resets.
    act = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 149) == 0) act = !act;
      cycle(($urandom_range(0, 599) == 0), act, 1'($urandom_range(0, 1)), 16'($urandom));
    end
    repeat (48) cycle(1'b0, 1'b1, 1'b0, 16'h0);
    chk("scoreboard_drain", acc_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptos_idle_multilane.md
Name: ptos_idle_multilane

Overview:
Parametrised multi-lane parallel-to-serial transmitter with IDLE-symbol insertion and link bring-up, for the PCIe physical-layer transmit path. Each lane serialises one WIDTH-bit symbol per WIDTH clocks. After `active` rises, the block sends MIN_IDLE IDLE symbols before accepting data. In the run state, it fills gaps in `in_valid` with IDLE symbols. This block succeeds the single-lane fixed-width parallel-to-serial IDLE block.

Parameters:
- WIDTH, 8, symbol width in bits; also the serial clocks per symbol.
- LANES, 2, number of serial lanes; all lanes share one symbol boundary.
- IDLE_SYM, 8'hBC, filler/warm-up symbol (K28.5); WIDTH bits.
- MIN_IDLE, 4, number of IDLE symbols sent after activation before data is accepted; must be ≥1.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk, input, 1, serial bit clock.
- reset, input, 1, synchronous, active-high.
- active, input, 1, link enable.
- in_data, input, LANES*WIDTH, lane i = in_data[i*WIDTH +: WIDTH].
- in_valid, input, 1, in_data holds a symbol for all lanes.
- in_ready, output, 1, symbol accepted this cycle when in_valid && in_ready.
- out_serial, output, LANES, serial bit per lane.
- sym_start, output, 1, high on the first bit of each transmitted symbol.
- is_idle, output, 1, the symbol currently on out_serial is IDLE_SYM filler.
- link_up, output, 1, state == RUN.

Behaviour:
- Reset (dominates active):
  - state = OFF; bit counter cnt = 0; idle_cnt = 0; all shift registers = 0.
  - out_serial = 0, in_ready = 0, sym_start = 0, is_idle = 0, link_up = 0.
- cnt counts 0..WIDTH-1 and wraps. A boundary is the cycle where cnt == WIDTH-1; the next symbol loads at that edge. In non-boundary cycles the shift registers shift one bit.
- out_serial[i] is combinational from the shift register edge bit (MSB or LSB per MSB_FIRST).
- OFF:
  - cnt is held at 0 and out_serial = 0.
  - Edge with active = 1: go to WARMUP, load IDLE_SYM into all lanes, cnt = 0, idle_cnt = 1, is_idle = 1.
  - First IDLE bit appears the cycle after active is sampled high.
- WARMUP, at each boundary:
  - If active == 0: go to OFF and load 0.
  - Else if idle_cnt < MIN_IDLE: load IDLE_SYM and increment idle_cnt.
  - Else: go to RUN and perform the RUN load below.
- RUN, at each boundary:
  - If active == 0: go to OFF and load 0. The current symbol always completes all WIDTH bits.
  - Else if in_valid: load in_data per lane, is_idle = 0.
  - Else: load IDLE_SYM, is_idle = 1.
- in_ready = active && cnt == WIDTH-1 && (state == RUN || (state == WARMUP && idle_cnt == MIN_IDLE)). It is combinational and high at most one cycle per WIDTH.
- Data is never dropped: a transfer happens only on in_valid && in_ready. A held in_valid waits for the next boundary.
- sym_start = (state != OFF) && cnt == 0. It is registered, aligned with the first bit.
- active toggling mid-symbol has no effect until the boundary. Any return to OFF forces a full MIN_IDLE warm-up on reactivation.
- Width rules:
  - cnt width is $clog2(WIDTH).
  - idle_cnt width is $clog2(MIN_IDLE+1).
  - IDLE_SYM is truncated or zero-extended to WIDTH.

Decomposition:
- Shared package ptos_pkg:
  - state enum {OFF, WARMUP, RUN};
  - K28_5 constant 8'hBC;
  - helper for the counter width.
- Sub-module ptos_lane_shifter: per-lane load/shift register with MSB_FIRST selection, instantiated LANES times via generate.
- Control FSM, counters and handshake live in the top module.

Test Plan (WIDTH=8, LANES=2, MIN_IDLE=4, MSB_FIRST=1):
- Reset held 3 cycles with active = 1 → out_serial = 2'b00, in_ready = 0, link_up = 0, sym_start = 0 throughout.
- active rises, in_valid = 0 → each lane emits 1,0,1,1,1,1,0,0 four times. in_ready first pulses on the last bit of the 4th IDLE, then link_up = 1. Filler BC continues with is_idle = 1.
- RUN with in_valid held and in_data = 16'hA55A → lane0 emits 0,1,0,1,1,0,1,0 and lane1 emits 1,0,1,0,0,1,0,1. in_ready pulses once per 8 cycles; is_idle = 0.
- Sequence 0x1111, in_valid low one boundary, 0x2222 → per-lane symbols 11, BC, 22 back-to-back; no symbol lost or duplicated.
- active drops at bit 3 of a data symbol → remaining 5 bits sent, then out_serial = 0, link_up = 0, in_ready = 0. Reasserting active repeats the full 4×BC warm-up.
- reset asserted mid-symbol in RUN → next cycle all outputs 0 and state OFF; the partially sent symbol is discarded.
